// File: rtl/ahb_pkg.sv
// Shared AHB-Lite/AHB5 definitions used by the slave memory.
// Contents: transfer-type and size encodings, response constants,
// the slave data-phase state encoding, and byte-lane helper functions.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_128   = 3'd4,
        SIZE_256   = 3'd5,
        SIZE_512   = 3'd6,
        SIZE_1024  = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Widest supported bus is 128 bits, so lane masks are returned at
    // 16 bits and the caller keeps the low DATAWIDTH/8 of them.
    localparam int STRB_MAX = 16;

    // Bytes touched by a transfer of 2^hsize bytes starting at addr_lsb.
    function automatic logic [STRB_MAX-1:0] lane_mask(input logic [3:0] addr_lsb,
                                                      input logic [2:0] hsize);
        logic [STRB_MAX-1:0] base;
        case (hsize)
            3'd0:    base = 16'h0001;
            3'd1:    base = 16'h0003;
            3'd2:    base = 16'h000F;
            3'd3:    base = 16'h00FF;
            3'd4:    base = 16'hFFFF;
            default: base = 16'h0000;
        endcase
        return base << addr_lsb;
    endfunction

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [6:0] align_mask(input logic [2:0] hsize);
        logic [6:0] m;
        case (hsize)
            3'd0:    m = 7'h00;
            3'd1:    m = 7'h01;
            3'd2:    m = 7'h03;
            3'd3:    m = 7'h07;
            3'd4:    m = 7'h0F;
            3'd5:    m = 7'h1F;
            3'd6:    m = 7'h3F;
            default: m = 7'h7F;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// Word-organised storage for the AHB slave memory.
// Ports: hclk (write clock), we/waddr/wbe/wdata (byte-enabled write port),
// raddr/rdata (asynchronous read port). Contents are never reset.
module ahb_slv_mem_array #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int AW        = 10
) (
    input  logic                   hclk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DATAWIDTH/8-1:0] wbe,
    input  logic [DATAWIDTH-1:0]   wdata,
    input  logic [AW-1:0]          raddr,
    output logic [DATAWIDTH-1:0]   rdata
);

    localparam int STRB = DATAWIDTH / 8;

    logic [DATAWIDTH-1:0] mem_r [DEPTH];

    // Byte-granular write of the enabled lanes.
    always_ff @(posedge hclk) begin
        for (int b = 0; b < STRB; b++) begin
            if (we && wbe[b]) begin
                mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_slv_mem.sv
// AHB-Lite/AHB5 slave backed by a byte-addressable memory.
// Inputs: hclk, hreset (sync, active high), hsel, haddr, htrans, hsize,
// hburst (unused), hwrite, hwdata, hwstrb, hready.
// Outputs (all registered): hreadyout, hresp, hrdata.
// Supports programmable wait states, a two-cycle ERROR response for
// out-of-range, misaligned or oversized transfers, and optional hwstrb masking.
module ahb_slv_mem
    import ahb_pkg::*;
#(
    parameter int DATAWIDTH   = 32,
    parameter int ADDRWIDTH   = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int HWSTRB_EN   = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic [ADDRWIDTH-1:0]   haddr,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic                   hwrite,
    input  logic [DATAWIDTH-1:0]   hwdata,
    input  logic [DATAWIDTH/8-1:0] hwstrb,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [DATAWIDTH-1:0]   hrdata
);

    localparam int         STRB     = DATAWIDTH / 8;
    localparam int         BSHIFT   = $clog2(STRB);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LAST  = 4'(WAIT_STATES);
    localparam logic [2:0] SIZE_MAX = 3'(BSHIFT);

    slv_state_e           state_r, next_state_s;
    logic [3:0]           wcnt_r;
    logic                 dp_valid_r, dp_write_r;
    logic [AW-1:0]        dp_word_r;
    logic [STRB-1:0]      dp_mask_r;
    logic                 hreadyout_r, hresp_r;
    logic [DATAWIDTH-1:0] hrdata_r;

    logic                 accept_s, take_s, err_s, complete_s, we_s, fwd_s, rd_now_s;
    logic [ADDRWIDTH-1:0] word_full_s;
    logic [AW-1:0]        addr_word_s, rd_word_s;
    logic [STRB_MAX-1:0]  lane16_s;
    logic [STRB-1:0]      addr_mask_s, wbe_s;
    logic [DATAWIDTH-1:0] bm_s, arr_rdata_s, rd_merge_s;
    logic                 hreadyout_nxt_s, hresp_nxt_s;
    logic [DATAWIDTH-1:0] hrdata_nxt_s;
    logic                 unused_s;

    // Address-phase decode and error classification.
    assign accept_s    = hsel & hready & htrans[1];
    assign take_s      = accept_s & ((state_r == ST_IDLE) | (state_r == ST_ERR2));
    assign word_full_s = haddr >> BSHIFT;
    assign addr_word_s = word_full_s[AW-1:0];
    assign err_s       = (word_full_s >= ADDRWIDTH'(DEPTH))
                       | (|(haddr[6:0] & align_mask(hsize)))
                       | (hsize > SIZE_MAX);
    assign lane16_s    = lane_mask(4'(haddr[BSHIFT-1:0]), hsize);
    assign addr_mask_s = lane16_s[STRB-1:0];

    // Only OKAY transfers are ever pending, so IDLE with a pending beat
    // is exactly the completing cycle.
    assign complete_s = dp_valid_r & (state_r == ST_IDLE);
    assign we_s       = complete_s & dp_write_r & ~hreset;
    assign wbe_s      = dp_mask_r & ((HWSTRB_EN != 0) ? hwstrb : {STRB{1'b1}});

    // Read the new address when a zero-wait read is taken now, otherwise the held one.
    assign rd_word_s = take_s ? addr_word_s : dp_word_r;
    assign rd_now_s  = (take_s & ~err_s & ~hwrite & (WAIT_STATES == 0))
                     | ((state_r == ST_WAIT) & (wcnt_r == WS_LAST) & dp_valid_r & ~dp_write_r);

    // A write committing this edge to the word being read is merged in.
    assign fwd_s      = we_s & (dp_word_r == rd_word_s);
    assign rd_merge_s = fwd_s ? ((arr_rdata_s & ~bm_s) | (hwdata & bm_s)) : arr_rdata_s;

    assign unused_s = ^{hburst, htrans[0], lane16_s};

    // Expand the byte enables to a bit mask for forwarding.
    always_comb begin
        bm_s = {DATAWIDTH{1'b0}};
        for (int b = 0; b < STRB; b++) begin
            bm_s[b*8 +: 8] = {8{wbe_s[b]}};
        end
    end

    ahb_slv_mem_array #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_array (
        .hclk  (hclk),
        .we    (we_s),
        .waddr (dp_word_r),
        .wbe   (wbe_s),
        .wdata (hwdata),
        .raddr (rd_word_s),
        .rdata (arr_rdata_s)
    );

    // State register and wait-state counter.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r <= ST_IDLE;
            wcnt_r  <= 4'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == ST_WAIT) begin
                wcnt_r <= (state_r == ST_WAIT) ? (wcnt_r + 4'd1) : 4'd1;
            end else begin
                wcnt_r <= 4'd0;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (take_s) begin
                    if (err_s) begin
                        next_state_s = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wcnt_r == WS_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ERR1: next_state_s = ST_ERR2;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next-cycle bus outputs derived from the state being entered.
    always_comb begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_OKAY;
        hrdata_nxt_s    = {DATAWIDTH{1'b0}};
        case (next_state_s)
            ST_WAIT: hreadyout_nxt_s = 1'b0;
            ST_ERR1: begin
                hreadyout_nxt_s = 1'b0;
                hresp_nxt_s     = HRESP_ERROR;
            end
            ST_ERR2: hresp_nxt_s = HRESP_ERROR;
            ST_IDLE: begin
                if (rd_now_s) begin
                    hrdata_nxt_s = rd_merge_s;
                end else begin
                    hrdata_nxt_s = {DATAWIDTH{1'b0}};
                end
            end
            default: begin
                hreadyout_nxt_s = 1'b1;
                hresp_nxt_s     = HRESP_OKAY;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= {DATAWIDTH{1'b0}};
        end else begin
            hreadyout_r <= hreadyout_nxt_s;
            hresp_r     <= hresp_nxt_s;
            hrdata_r    <= hrdata_nxt_s;
        end
    end

    // Captured address phase of the pending OKAY transfer.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_word_r  <= {AW{1'b0}};
            dp_mask_r  <= {STRB{1'b0}};
        end else if (take_s) begin
            dp_valid_r <= ~err_s;
            dp_write_r <= hwrite;
            dp_word_r  <= addr_word_s;
            dp_mask_r  <= addr_mask_s;
        end else if (complete_s) begin
            dp_valid_r <= 1'b0;
        end
    end

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign hrdata    = hrdata_r;

endmodule

// File: tb/tb_ahb_slv_mem.sv
module tb_ahb_slv_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_b;
    logic        dsel;      // 0: zero-wait/strobed instance, 1: three-wait instance
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hreadyout0, hresp0, hreadyout3, hresp3;
    logic [31:0] hrdata0, hrdata3;
    logic        rdy_s, resp_s;
    logic [31:0] rdata_s;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    assign rdy_s   = dsel ? hreadyout3 : hreadyout0;
    assign resp_s  = dsel ? hresp3 : hresp0;
    assign rdata_s = dsel ? hrdata3 : hrdata0;

    ahb_slv_mem #(.DATAWIDTH(32), .ADDRWIDTH(32), .DEPTH(1024), .WAIT_STATES(0), .HWSTRB_EN(1)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b & ~dsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(hreadyout0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_slv_mem #(.DATAWIDTH(32), .ADDRWIDTH(32), .DEPTH(1024), .WAIT_STATES(3), .HWSTRB_EN(0)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b & dsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(hreadyout3), .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3)
    );

    // One isolated transfer; entered and left on a falling edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output int low,
                        output logic resp_low, output logic resp_done);
        hsel_b = 1'b1; htrans = 2'd2; haddr = addr; hsize = size; hwrite = wr;
        @(posedge hclk); @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'd0; hwdata = wdata; hwstrb = strb;
        low = 0;
        resp_low = 1'b0;
        while (rdy_s !== 1'b1 && low < 40) begin
            resp_low = resp_low | resp_s;
            low++;
            @(negedge hclk);
        end
        rdata = rdata_s;
        resp_done = resp_s;
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hreset = 1'b1; hsel_b = 1'b0; dsel = 1'b0; haddr = 32'h0; htrans = 2'd0;
        hsize = 3'd2; hburst = 3'd0; hwrite = 1'b0; hwdata = 32'h0; hwstrb = 4'hF;
        repeat (3) @(negedge hclk);
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b expected 1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_resp0: got %b expected 0", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0: got %h expected 0", hrdata0); end
        checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL rst_ready3: got %b expected 1", hreadyout3); end
        checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL rst_resp3: got %b expected 0", hresp3); end
        checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL rst_rdata3: got %h expected 0", hrdata3); end
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int low; logic rl, rdn;
        dsel = 1'b0;
        hsel_b = 1'b1; htrans = 2'd2; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
        @(posedge hclk); @(negedge hclk);
        checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 1", rdy_s); end
        checks++; if (resp_s !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp: got %b expected 0", resp_s); end
        hwdata = 32'hDEADBEEF; hwstrb = 4'hF; hwrite = 1'b0;
        @(posedge hclk); @(negedge hclk);
        checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b expected 1", rdy_s); end
        checks++; if (resp_s !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp: got %b expected 0", resp_s); end
        checks++; if (rdata_s !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd_data: got %h expected deadbeef", rdata_s); end
        hsel_b = 1'b0; htrans = 2'd0;
        @(posedge hclk); @(negedge hclk);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL b2b_rdata_idle: got %h expected 0", rdata_s); end
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_reread: got %h expected deadbeef", rd); end
        checks++; if (low !== 0) begin errors++; $display("FAIL b2b_reread_waits: got %0d expected 0", low); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int low; logic rl, rdn;
        dsel = 1'b0;
        xfer(1'b1, 32'h10, 3'd2, 32'h11223344, 4'hF, rd, low, rl, rdn);
        xfer(1'b1, 32'h13, 3'd0, 32'hABABABAB, 4'hF, rd, low, rl, rdn);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'hAB223344) begin errors++; $display("FAIL byte_write: got %h expected ab223344", rd); end
        xfer(1'b1, 32'h12, 3'd1, 32'h99887766, 4'hF, rd, low, rl, rdn);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'h99883344) begin errors++; $display("FAIL half_write: got %h expected 99883344", rd); end
    endtask

    task automatic test_hwstrb();
        logic [31:0] rd; int low; logic rl, rdn;
        dsel = 1'b0;
        xfer(1'b1, 32'h40, 3'd2, 32'h00000000, 4'hF, rd, low, rl, rdn);
        xfer(1'b1, 32'h40, 3'd2, 32'hFFFFFFFF, 4'b0101, rd, low, rl, rdn);
        xfer(1'b0, 32'h40, 3'd2, 32'h0, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'h00FF00FF) begin errors++; $display("FAIL hwstrb_mask: got %h expected 00ff00ff", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; int low; logic rl, rdn;
        logic [31:0] addrs [3];
        logic [2:0]  sizes [3];
        addrs[0] = 32'h1000; sizes[0] = 3'd2;   // word index 1024, aliases word 0 if unchecked
        addrs[1] = 32'h0001; sizes[1] = 3'd1;   // misaligned halfword
        addrs[2] = 32'h0000; sizes[2] = 3'd3;   // 8 bytes on a 4-byte bus
        dsel = 1'b0;
        xfer(1'b1, 32'h0, 3'd2, 32'h0BADF00D, 4'hF, rd, low, rl, rdn);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, addrs[i], sizes[i], 32'hFFFFFFFF, 4'hF, rd, low, rl, rdn);
            checks++; if (low !== 1) begin errors++; $display("FAIL err%0d_low_cycles: got %0d expected 1", i, low); end
            checks++; if (rl !== 1'b1) begin errors++; $display("FAIL err%0d_resp_err1: got %b expected 1", i, rl); end
            checks++; if (rdn !== 1'b1) begin errors++; $display("FAIL err%0d_resp_err2: got %b expected 1", i, rdn); end
        end
        xfer(1'b0, 32'h0, 3'd2, 32'h0, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL err_mem_unchanged: got %h expected 0badf00d", rd); end
        checks++; if (rdn !== 1'b0) begin errors++; $display("FAIL err_recover_resp: got %b expected 0", rdn); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int low; logic rl, rdn;
        dsel = 1'b1;
        xfer(1'b1, 32'h20, 3'd2, 32'h12345678, 4'hF, rd, low, rl, rdn);
        checks++; if (low !== 3) begin errors++; $display("FAIL ws_write_low: got %0d expected 3", low); end
        xfer(1'b1, 32'h24, 3'd2, 32'hCAFEF00D, 4'hF, rd, low, rl, rdn);
        hsel_b = 1'b1; htrans = 2'd2; haddr = 32'h20; hsize = 3'd2; hwrite = 1'b0;
        @(posedge hclk); @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'd0;
        low = 0;
        while (rdy_s !== 1'b1 && low < 40) begin low++; @(negedge hclk); end
        checks++; if (low !== 3) begin errors++; $display("FAIL ws_read1_low: got %0d expected 3", low); end
        checks++; if (rdata_s !== 32'h12345678) begin errors++; $display("FAIL ws_read1_data: got %h expected 12345678", rdata_s); end
        checks++; if (resp_s !== 1'b0) begin errors++; $display("FAIL ws_read1_resp: got %b expected 0", resp_s); end
        // next address phase overlaps the completing cycle
        hsel_b = 1'b1; htrans = 2'd2; haddr = 32'h24;
        @(posedge hclk); @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'd0;
        low = 0;
        while (rdy_s !== 1'b1 && low < 40) begin low++; @(negedge hclk); end
        checks++; if (low !== 3) begin errors++; $display("FAIL ws_read2_low: got %0d expected 3", low); end
        checks++; if (rdata_s !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_read2_data: got %h expected cafef00d", rdata_s); end
        @(negedge hclk);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; int low; logic rl, rdn;
        dsel = 1'b1;
        xfer(1'b1, 32'h30, 3'd2, 32'h5A5A5A5A, 4'hF, rd, low, rl, rdn);
        hsel_b = 1'b1; htrans = 2'd2; haddr = 32'h30; hsize = 3'd2; hwrite = 1'b1;
        @(posedge hclk); @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL rw_wait1_ready: got %b expected 0", rdy_s); end
        @(posedge hclk); @(negedge hclk);
        hreset = 1'b1;
        @(posedge hclk); @(negedge hclk);
        hreset = 1'b0;
        checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b expected 1", rdy_s); end
        checks++; if (resp_s !== 1'b0) begin errors++; $display("FAIL rw_resp: got %b expected 0", resp_s); end
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL rw_rdata: got %h expected 0", rdata_s); end
        xfer(1'b0, 32'h30, 3'd2, 32'hFFFFFFFF, 4'hF, rd, low, rl, rdn);
        checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL rw_old_value: got %h expected 5a5a5a5a", rd); end
        checks++; if (low !== 3) begin errors++; $display("FAIL rw_read_low: got %0d expected 3", low); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_hwstrb();
        test_errors();
        test_wait_states();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
